aud_play_ctrl: RTL

- Playback sequencer for the I2S DAC serializer.
- Fetches 16-bit mono samples from the recording SRAM over a req/ack port and presents one sample per LRCK frame on o_dac_data.
- Gates the serializer through o_player_en and implements play/pause/stop with fast (sample skip) and slow (sample repeat) speed control.
- Runs entirely in the i_bclk domain, beside the serializer and under the top-level FSM.

---
 rtl/aud_play_ctrl.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aud_play_ctrl.sv
// -----------------------------------------------------------------------------
// aud_play_ctrl
// Playback sequencer for the I2S DAC serializer. Fetches 16-bit mono samples
// from the recording SRAM over a req/ack port and presents one sample per
// LRCK frame. Supports play / pause / stop, fast mode (skip i_speed samples)
// and slow mode (repeat each sample i_speed+1 times).
//
// Ports
//   i_bclk      bit clock, all logic on posedge
//   i_rst_n     asynchronous active-low reset
//   i_daclrck   DAC LR clock (low = left half)
//   i_play      pulse: start from IDLE/DONE, resume from PAUSE
//   i_pause     pulse: pause playback
//   i_stop      pulse: stop and rewind to address 0
//   i_fast      1 = skip mode, 0 = repeat mode
//   i_speed     speed factor minus 1
//   i_end_addr  last valid sample address (inclusive)
//   o_mem_req   SRAM read request, held until acknowledged
//   o_mem_addr  SRAM read address, stable while o_mem_req=1
//   i_mem_ack   read data valid (only honoured while o_mem_req=1)
//   i_mem_data  signed read data
//   o_player_en serializer enable
//   o_dac_data  sample presented to the serializer
//   o_state     0=IDLE 1=PLAY 2=PAUSE 3=DONE
//   o_done      high while in DONE
//   o_underrun  one-cycle pulse when a frame tick finds the buffer empty
// -----------------------------------------------------------------------------
module aud_play_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int LOAD_OFFSET = 18
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_data,
    output logic              o_player_en,
    output logic [15:0]       o_dac_data,
    output logic [1:0]        o_state,
    output logic              o_done,
    output logic              o_underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int                CNT_W    = $clog2(LOAD_OFFSET + 1);
    localparam logic [CNT_W-1:0]  TICK_AT  = CNT_W'(LOAD_OFFSET);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    // Frame tick generation
    logic             lrck_d_r;
    logic             tick_busy_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic             rise_s;
    logic             tick_s;

    // FSM and datapath state
    logic [1:0]        state_r,      state_nxt_s;
    logic [ADDR_W:0]   next_addr_r,  next_addr_nxt_s;   // MSB is the carry/past-end bit
    logic [15:0]       buf_r,        buf_nxt_s;
    logic              buf_full_r,   buf_full_nxt_s;
    logic [2:0]        rep_cnt_r,    rep_cnt_nxt_s;
    logic [2:0]        speed_q_r,    speed_q_nxt_s;
    logic              fast_q_r,     fast_q_nxt_s;
    logic              mem_req_r,    mem_req_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r,   mem_addr_nxt_s;
    logic [15:0]       dac_r,        dac_nxt_s;
    logic              en_r,         en_nxt_s;
    logic              done_r,       done_nxt_s;
    logic              underrun_r,   underrun_nxt_s;

    // Derived control terms
    logic              past_end_s;
    logic              stay_play_s;
    logic              start_s;
    logic              present_s;
    logic              fetch_s;
    logic              speed_chg_s;
    logic [2:0]        rep_eff_s;
    logic [ADDR_W:0]   step_s;

    assign rise_s = ~lrck_d_r & i_daclrck;
    assign tick_s = tick_busy_r & (tick_cnt_r == TICK_AT);

    // LRCK rising-edge detector and LOAD_OFFSET delay counter; a new edge restarts the count
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d_r    <= 1'b1;
            tick_busy_r <= 1'b0;
            tick_cnt_r  <= CNT_ZERO;
        end else begin
            lrck_d_r <= i_daclrck;
            if (rise_s) begin
                tick_busy_r <= 1'b1;
                tick_cnt_r  <= CNT_ONE;
            end else if (tick_s) begin
                tick_busy_r <= 1'b0;
                tick_cnt_r  <= CNT_ZERO;
            end else if (tick_busy_r) begin
                tick_cnt_r <= tick_cnt_r + CNT_ONE;
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
        end
    end

    // A carried sum is past the end even though its low bits may be small
    assign past_end_s  = next_addr_r[ADDR_W] | (next_addr_r[ADDR_W-1:0] > i_end_addr);
    assign stay_play_s = (state_r == ST_PLAY) & (state_nxt_s == ST_PLAY);
    assign start_s     = ((state_r == ST_IDLE) | (state_r == ST_DONE)) & (state_nxt_s == ST_PLAY);
    assign present_s   = stay_play_s & tick_s & buf_full_r;
    assign fetch_s     = stay_play_s & ~buf_full_r & ~mem_req_r & ~past_end_s;
    // Any change of speed settings restarts the repeat count for this tick
    assign speed_chg_s = (i_speed != speed_q_r) | (i_fast != fast_q_r);
    assign rep_eff_s   = speed_chg_s ? 3'd0 : rep_cnt_r;
    assign step_s      = {{(ADDR_W-2){1'b0}}, i_speed} + {{ADDR_W{1'b0}}, 1'b1};

    // FSM state register
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode; priority stop > pause > play
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_stop)       state_nxt_s = ST_IDLE;
                else if (i_pause) state_nxt_s = ST_IDLE;
                else if (i_play)  state_nxt_s = ST_PLAY;
                else              state_nxt_s = ST_IDLE;
            end
            ST_PLAY: begin
                if (i_stop)       state_nxt_s = ST_IDLE;
                else if (i_pause) state_nxt_s = ST_PAUSE;
                else if (tick_s && !buf_full_r && past_end_s && !mem_req_r)
                                  state_nxt_s = ST_DONE;
                else              state_nxt_s = ST_PLAY;
            end
            ST_PAUSE: begin
                if (i_stop)       state_nxt_s = ST_IDLE;
                else if (i_pause) state_nxt_s = ST_PAUSE;
                else if (i_play)  state_nxt_s = ST_PLAY;
                else              state_nxt_s = ST_PAUSE;
            end
            ST_DONE: begin
                if (i_stop)       state_nxt_s = ST_IDLE;
                else if (i_pause) state_nxt_s = ST_DONE;
                else if (i_play)  state_nxt_s = ST_PLAY;
                else              state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        next_addr_nxt_s = next_addr_r;
        buf_nxt_s       = buf_r;
        buf_full_nxt_s  = buf_full_r;
        rep_cnt_nxt_s   = rep_cnt_r;
        speed_q_nxt_s   = speed_q_r;
        fast_q_nxt_s    = fast_q_r;
        mem_req_nxt_s   = mem_req_r;
        mem_addr_nxt_s  = mem_addr_r;
        dac_nxt_s       = dac_r;
        en_nxt_s        = en_r;
        underrun_nxt_s  = 1'b0;
        if (i_stop) begin
            // Abort any in-flight request; a late ack then sees req=0 and is ignored
            next_addr_nxt_s = {(ADDR_W+1){1'b0}};
            buf_full_nxt_s  = 1'b0;
            rep_cnt_nxt_s   = 3'd0;
            mem_req_nxt_s   = 1'b0;
            mem_addr_nxt_s  = {ADDR_W{1'b0}};
            dac_nxt_s       = 16'd0;
            en_nxt_s        = 1'b0;
        end else if (start_s) begin
            // Prefetch address 0 right away rather than waiting for a tick
            next_addr_nxt_s = {(ADDR_W+1){1'b0}};
            buf_full_nxt_s  = 1'b0;
            rep_cnt_nxt_s   = 3'd0;
            speed_q_nxt_s   = i_speed;
            fast_q_nxt_s    = i_fast;
            mem_req_nxt_s   = 1'b1;
            mem_addr_nxt_s  = {ADDR_W{1'b0}};
            en_nxt_s        = 1'b0;
        end else begin
            if (mem_req_r && i_mem_ack) begin
                buf_nxt_s      = i_mem_data;
                buf_full_nxt_s = 1'b1;
                mem_req_nxt_s  = 1'b0;
            end else if (fetch_s) begin
                mem_req_nxt_s  = 1'b1;
                mem_addr_nxt_s = next_addr_r[ADDR_W-1:0];
            end else begin
                mem_req_nxt_s  = mem_req_r;
            end

            if (present_s) begin
                dac_nxt_s      = buf_r;
                buf_full_nxt_s = 1'b0;
                en_nxt_s       = 1'b1;
                speed_q_nxt_s  = i_speed;
                fast_q_nxt_s   = i_fast;
                if (i_fast) begin
                    next_addr_nxt_s = next_addr_r + step_s;
                    rep_cnt_nxt_s   = 3'd0;
                end else if (rep_eff_s >= i_speed) begin
                    next_addr_nxt_s = next_addr_r + {{ADDR_W{1'b0}}, 1'b1};
                    rep_cnt_nxt_s   = 3'd0;
                end else begin
                    // Same address is refetched for the next repeat
                    rep_cnt_nxt_s   = rep_eff_s + 3'd1;
                end
            end else if (stay_play_s && tick_s) begin
                speed_q_nxt_s  = i_speed;
                fast_q_nxt_s   = i_fast;
                rep_cnt_nxt_s  = rep_eff_s;
                underrun_nxt_s = 1'b1;
            end else begin
                underrun_nxt_s = 1'b0;
            end

            if (state_nxt_s != ST_PLAY) begin
                en_nxt_s = 1'b0;
            end else begin
                en_nxt_s = en_nxt_s;
            end
        end
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            next_addr_r <= {(ADDR_W+1){1'b0}};
            buf_r       <= 16'd0;
            buf_full_r  <= 1'b0;
            rep_cnt_r   <= 3'd0;
            speed_q_r   <= 3'd0;
            fast_q_r    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            dac_r       <= 16'd0;
            en_r        <= 1'b0;
            done_r      <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            next_addr_r <= next_addr_nxt_s;
            buf_r       <= buf_nxt_s;
            buf_full_r  <= buf_full_nxt_s;
            rep_cnt_r   <= rep_cnt_nxt_s;
            speed_q_r   <= speed_q_nxt_s;
            fast_q_r    <= fast_q_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            dac_r       <= dac_nxt_s;
            en_r        <= en_nxt_s;
            done_r      <= done_nxt_s;
            underrun_r  <= underrun_nxt_s;
        end
    end

    assign o_state     = state_r;
    assign o_mem_req   = mem_req_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_dac_data  = dac_r;
    assign o_player_en = en_r;
    assign o_done      = done_r;
    assign o_underrun  = underrun_r;

endmodule
